// File: rtl/alu2_pkg.sv
// Shared alu_2 definitions: opcode values, action field positions, issue FSM states and
// opcode classification helpers.
package alu2_pkg;

   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_ADDI  = 4'b1001;
   localparam logic [3:0] OP_SUBI  = 4'b1010;
   localparam logic [3:0] OP_STORE = 4'b1000;
   localparam logic [3:0] OP_LOAD  = 4'b1011;

   localparam int unsigned OPCODE_MSB = 24;
   localparam int unsigned OPCODE_LSB = 21;
   localparam int unsigned SRC1_MSB   = 20;
   localparam int unsigned SRC1_LSB   = 16;
   localparam int unsigned SRC2_MSB   = 15;
   localparam int unsigned SRC2_LSB   = 11;
   localparam int unsigned IMM_MSB    = 15;
   localparam int unsigned IMM_LSB    = 0;
   localparam int unsigned SRC_W      = 5;

   typedef enum logic [0:0] {
      IDLE_S = 1'b0,
      BUSY_S = 1'b1
   } alu2_state_e;

   function automatic logic is_supported(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_STORE, OP_LOAD: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Every opcode with bit 3 set takes its second operand from imm16.
   function automatic logic uses_imm(input logic [3:0] op);
      return op[3];
   endfunction

endpackage

// File: rtl/alu2_operand_fetch_if.sv
// Upstream PHV+action handshake into the alu_2 operand-fetch stage.
interface alu2_operand_fetch_if #(
   parameter int unsigned DATA_WIDTH = 48,
   parameter int unsigned NUM_CONT   = 24,
   parameter int unsigned ACTION_LEN = 25
);

   logic                           in_valid;
   logic                           in_ready;
   logic [NUM_CONT*DATA_WIDTH-1:0] phv_in;
   logic [ACTION_LEN-1:0]          action_in;
   logic                           act_en;

   modport master (
      output in_valid,
      output phv_in,
      output action_in,
      output act_en,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  phv_in,
      input  action_in,
      input  act_en,
      output in_ready
   );

endinterface

// File: rtl/alu2_opsel.sv
// Combinational PHV container selector; an index past the last container yields zero.
module alu2_opsel
   import alu2_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 48,
   parameter int unsigned NUM_CONT   = 24
) (
   input  logic [NUM_CONT*DATA_WIDTH-1:0] phv,
   input  logic [SRC_W-1:0]               idx,
   output logic [DATA_WIDTH-1:0]          operand
);

   always_comb begin
      operand = '0;
      for (int unsigned k = 0; k < NUM_CONT; k++) begin
         if (32'(idx) == k) begin
            operand = phv[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/alu2_operand_fetch.sv
// Issue stage feeding one alu_2 lane: one-entry PHV+action buffer, operand select, issue FSM
// with watchdog. Define ALU2_OPFETCH_PERF_EN to add issue_cnt/stall_cnt counter ports.
module alu2_operand_fetch
   import alu2_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 48,
   parameter int unsigned NUM_CONT   = 24,
   parameter int unsigned ACTION_LEN = 25,
   parameter int unsigned LANE_IDX   = 0,
   parameter int unsigned TIMEOUT    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   alu2_operand_fetch_if.slave   up,
   output logic [ACTION_LEN-1:0] alu_action,
   output logic                  alu_action_valid,
   output logic [DATA_WIDTH-1:0] alu_operand_1,
   output logic [DATA_WIDTH-1:0] alu_operand_2,
   output logic [DATA_WIDTH-1:0] alu_operand_3,
   input  logic                  alu_done,
   output logic                  busy,
   output logic                  err_timeout
`ifdef ALU2_OPFETCH_PERF_EN
   ,
   output logic [31:0]           issue_cnt,
   output logic [31:0]           stall_cnt
`endif
);

   localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   alu2_state_e                    state_q, state_d;
   logic [WdW-1:0]                 wd_q, wd_d;
   logic                           buf_valid_q, buf_valid_d;
   logic [NUM_CONT*DATA_WIDTH-1:0] buf_phv_q, buf_phv_d;
   logic [ACTION_LEN-1:0]          buf_action_q, buf_action_d;
   logic                           buf_act_en_q, buf_act_en_d;
   logic [ACTION_LEN-1:0]          action_q, action_d;
   logic                           valid_q, valid_d;
   logic [DATA_WIDTH-1:0]          op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
   logic                           err_q, err_d;

   logic [3:0]                     opcode;
   logic                           issue;
   logic [DATA_WIDTH-1:0]          sel1, sel2, sel3, op2_mux;

   assign opcode = buf_action_q[OPCODE_MSB:OPCODE_LSB];
   assign issue  = (state_q == IDLE_S) && buf_valid_q && buf_act_en_q && is_supported(opcode);

   alu2_opsel #(.DATA_WIDTH(DATA_WIDTH), .NUM_CONT(NUM_CONT)) u_sel1 (
      .phv     (buf_phv_q),
      .idx     (buf_action_q[SRC1_MSB:SRC1_LSB]),
      .operand (sel1)
   );

   alu2_opsel #(.DATA_WIDTH(DATA_WIDTH), .NUM_CONT(NUM_CONT)) u_sel2 (
      .phv     (buf_phv_q),
      .idx     (buf_action_q[SRC2_MSB:SRC2_LSB]),
      .operand (sel2)
   );

   alu2_opsel #(.DATA_WIDTH(DATA_WIDTH), .NUM_CONT(NUM_CONT)) u_sel3 (
      .phv     (buf_phv_q),
      .idx     (SRC_W'(LANE_IDX)),
      .operand (sel3)
   );

   assign op2_mux = uses_imm(opcode) ? DATA_WIDTH'(buf_action_q[IMM_MSB:IMM_LSB]) : sel2;

   always_comb begin
      state_d      = state_q;
      wd_d         = wd_q;
      buf_valid_d  = buf_valid_q;
      buf_phv_d    = buf_phv_q;
      buf_action_d = buf_action_q;
      buf_act_en_d = buf_act_en_q;
      action_d     = action_q;
      valid_d      = 1'b0;
      op1_d        = op1_q;
      op2_d        = op2_q;
      op3_d        = op3_q;
      err_d        = err_q;

      // Capture only into an empty buffer; draining needs a full one, so the two never collide.
      if (up.in_valid && !buf_valid_q) begin
         buf_valid_d  = 1'b1;
         buf_phv_d    = up.phv_in;
         buf_action_d = up.action_in;
         buf_act_en_d = up.act_en;
      end

      unique case (state_q)
         IDLE_S: begin
            if (buf_valid_q) begin
               buf_valid_d = 1'b0;
               if (issue) begin
                  action_d = buf_action_q;
                  valid_d  = 1'b1;
                  op1_d    = sel1;
                  op2_d    = op2_mux;
                  op3_d    = sel3;
                  wd_d     = '0;
                  state_d  = BUSY_S;
               end
            end
         end
         BUSY_S: begin
            if (alu_done) begin
               state_d = IDLE_S;
            end else if (wd_q == WdW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE_S;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: state_d = IDLE_S;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE_S;
         wd_q         <= '0;
         buf_valid_q  <= 1'b0;
         buf_phv_q    <= '0;
         buf_action_q <= '0;
         buf_act_en_q <= 1'b0;
         action_q     <= '0;
         valid_q      <= 1'b0;
         op1_q        <= '0;
         op2_q        <= '0;
         op3_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wd_q         <= wd_d;
         buf_valid_q  <= buf_valid_d;
         buf_phv_q    <= buf_phv_d;
         buf_action_q <= buf_action_d;
         buf_act_en_q <= buf_act_en_d;
         action_q     <= action_d;
         valid_q      <= valid_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         op3_q        <= op3_d;
         err_q        <= err_d;
      end
   end

   assign up.in_ready        = ~buf_valid_q;
   assign alu_action         = action_q;
   assign alu_action_valid   = valid_q;
   assign alu_operand_1      = op1_q;
   assign alu_operand_2      = op2_q;
   assign alu_operand_3      = op3_q;
   assign busy               = (state_q == BUSY_S);
   assign err_timeout        = err_q;

`ifdef ALU2_OPFETCH_PERF_EN
   logic [31:0] issue_cnt_q, stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (issue) begin
            issue_cnt_q <= issue_cnt_q + 32'd1;
         end
         if (buf_valid_q && (state_q == BUSY_S)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign issue_cnt = issue_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule
